led_driver: RTL and testbench

LED_DRIVER -- requirements
Module: led_driver

---
 rtl/led_pkg.sv | 13 +
 rtl/led_tick_gen.sv | 27 ++
 rtl/led_driver.sv | 134 +++++++++++++
 tb/tb_led_driver.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared mode encodings and default parameters for the LED driver.
package led_pkg;
  typedef enum logic [1:0] {
    MODE_COUNT   = 2'b00,
    MODE_BOUNCE  = 2'b01,
    MODE_BREATHE = 2'b10,
    MODE_STATIC  = 2'b11
  } mode_e;

  localparam int          LED_NUM_DEF   = 10;
  localparam logic [19:0] LED_DEC_DEF   = 20'd16;
  localparam int          LED_PWM_W_DEF = 8;
endpackage

// File: rtl/led_tick_gen.sv
// Step prescaler: counts 0..DECIMATION-1 and strobes tick on the last count.
module led_tick_gen #(
  parameter logic [19:0] DECIMATION = 20'd16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic hold,
  output logic tick
);
  logic [19:0] cnt_q, cnt_d;
  logic        at_end;

  assign at_end = (cnt_q == DECIMATION - 20'd1);
  assign tick   = at_end & ~hold;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)      cnt_d = '0;
    else if (!hold) cnt_d = at_end ? '0 : cnt_q + 20'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/led_driver.sv
// LED pattern driver: count / bounce / breathe / static modes.
// Breathe PWM is only built when LED_DRIVER_BREATHE_EN is defined.
module led_driver
  import led_pkg::*;
#(
  parameter int          NUM_LED    = LED_NUM_DEF,
  parameter logic [19:0] DECIMATION = LED_DEC_DEF,
  parameter int          PWM_W      = LED_PWM_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         mode,
  input  logic [NUM_LED-1:0] pattern,
  input  logic               pause,
  output logic [NUM_LED-1:0] runled,
  output logic               tick
);
  // Asynchronous assert, synchronous release for everything below.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  mode_e              mode_q;
  logic               mode_chg, hold;
  logic [NUM_LED-1:0] step_q, step_d, runled_q, runled_d;
  logic               dir_q, dir_d;   // 0 = up, 1 = down
`ifdef LED_DRIVER_BREATHE_EN
  logic [PWM_W-1:0]   phase_q, phase_d, duty_q, duty_d;
  localparam logic [PWM_W-1:0] DUTY_MAX = {PWM_W{1'b1}};
`endif

  assign mode_chg = (mode != mode_q);
  assign hold     = pause & (mode_q != MODE_STATIC);

  led_tick_gen #(.DECIMATION(DECIMATION)) u_tick (
    .clk   (clk),
    .reset (rst_n),
    .clear (mode_chg),
    .hold  (hold),
    .tick  (tick)
  );

  always_comb begin
    step_d   = step_q;
    dir_d    = dir_q;
    runled_d = runled_q;
`ifdef LED_DRIVER_BREATHE_EN
    phase_d  = phase_q;
    duty_d   = duty_q;
`endif
    // A mode change wins over a coincident tick.
    if (mode_chg) begin
      step_d   = '0;
      dir_d    = 1'b0;
      runled_d = '0;
`ifdef LED_DRIVER_BREATHE_EN
      phase_d  = '0;
      duty_d   = '0;
`endif
    end else begin
      case (mode_q)
        MODE_COUNT: begin
          if (tick) step_d = step_q + NUM_LED'(1);
          runled_d = step_d;
        end
        MODE_BOUNCE: begin
          // Empty position means freshly started: first tick lights bit 0.
          if (tick) begin
            if (step_q == '0) begin
              step_d = NUM_LED'(1);
              dir_d  = 1'b0;
            end else if (!dir_q) begin
              step_d = step_q << 1;
              if (step_q[NUM_LED-2]) dir_d = 1'b1;
            end else begin
              step_d = step_q >> 1;
              if (step_q[1]) dir_d = 1'b0;
            end
          end
          runled_d = step_d;
        end
        MODE_BREATHE: begin
`ifdef LED_DRIVER_BREATHE_EN
          phase_d = phase_q + PWM_W'(1);
          if (tick) begin
            if (!dir_q) begin
              duty_d = duty_q + PWM_W'(1);
              if (duty_q == DUTY_MAX - PWM_W'(1)) dir_d = 1'b1;
            end else begin
              duty_d = duty_q - PWM_W'(1);
              if (duty_q == PWM_W'(1)) dir_d = 1'b0;
            end
          end
          runled_d = {NUM_LED{phase_q < duty_q}};
`else
          step_d   = '0;
          dir_d    = 1'b0;
          runled_d = '0;
`endif
        end
        MODE_STATIC: runled_d = pattern;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= MODE_COUNT;
      step_q   <= '0;
      dir_q    <= 1'b0;
      runled_q <= '0;
`ifdef LED_DRIVER_BREATHE_EN
      phase_q  <= '0;
      duty_q   <= '0;
`endif
    end else begin
      mode_q   <= mode_e'(mode);
      step_q   <= step_d;
      dir_q    <= dir_d;
      runled_q <= runled_d;
`ifdef LED_DRIVER_BREATHE_EN
      phase_q  <= phase_d;
      duty_q   <= duty_d;
`endif
    end
  end

  assign runled = runled_q;
endmodule

// File: tb/tb_led_driver.sv
// Directed bench for led_driver: two instances (10-LED default, 4-LED fast).
module tb_led_driver;
  logic       clk, reset;
  logic [1:0] mode_a, mode_b;
  logic [9:0] pattern_a, runled_a;
  logic [3:0] pattern_b, runled_b;
  logic       pause_a, pause_b, tick_a, tick_b;

  int n_err = 0;
  int n_chk = 0;

  led_driver #(.NUM_LED(10), .DECIMATION(20'd16), .PWM_W(8)) u_a (
    .clk(clk), .reset(reset), .mode(mode_a), .pattern(pattern_a),
    .pause(pause_a), .runled(runled_a), .tick(tick_a));

  led_driver #(.NUM_LED(4), .DECIMATION(20'd2), .PWM_W(4)) u_b (
    .clk(clk), .reset(reset), .mode(mode_b), .pattern(pattern_b),
    .pause(pause_b), .runled(runled_b), .tick(tick_b));

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] pattern;
    logic       pause;
    logic [9:0] exp;
  } vec_t;

  vec_t       tbl[6];
  logic [3:0] btbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_tick_a();
    bit ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tick_a) begin ok = 1; break; end
    end
    if (!ok) begin
      n_chk++; n_err++;
      $display("FAIL tick_a_timeout: got no tick expected tick within 40 cycles");
    end
  endtask

  task automatic wait_tick_b();
    bit ok = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tick_b) begin ok = 1; break; end
    end
    if (!ok) begin
      n_chk++; n_err++;
      $display("FAIL tick_b_timeout: got no tick expected tick within 10 cycles");
    end
  endtask

  task automatic step_a();
    wait_tick_a();
    @(posedge clk); #1;
  endtask

  task automatic step_b();
    wait_tick_b();
    @(posedge clk); #1;
  endtask

  // Count how many of 16 consecutive cycles have all LEDs lit.
  task automatic measure_b(output int ones, output bit mixed);
    ones = 0; mixed = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (runled_b == 4'hF) ones++;
      else if (runled_b != 4'h0) mixed = 1;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    bit bad;
    logic [9:0] prev;
`ifdef LED_DRIVER_BREATHE_EN
    int  ones;
    bit  mixed;
`endif
    tbl[0] = '{10'h2A5, 1'b1, 10'h2A5};
    tbl[1] = '{10'h2A5, 1'b0, 10'h2A5};
    tbl[2] = '{10'h000, 1'b0, 10'h000};
    tbl[3] = '{10'h3FF, 1'b1, 10'h3FF};
    tbl[4] = '{10'h155, 1'b0, 10'h155};
    tbl[5] = '{10'h201, 1'b1, 10'h201};
    btbl   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};

    clk = 0; reset = 0;
    mode_a = 2'b00; pattern_a = '0; pause_a = 0;
    mode_b = 2'b11; pattern_b = '0; pause_b = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_runled_a", runled_a, 0);
    chk("rst_tick_a", tick_a, 0);
    chk("rst_runled_b", runled_b, 0);

    // Two synchroniser edges, then counts 0..15: tick in the cycle after edge 17.
    @(negedge clk) reset = 1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (tick_a) break;
    end
    chk("first_tick_edge", n, 17);
    @(posedge clk); #1;
    chk("count_1", runled_a, 1);
    step_a();
    chk("count_2", runled_a, 2);
    repeat (5) step_a();
    chk("count_7", runled_a, 7);

    @(negedge clk) pause_a = 1;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (tick_a || runled_a != 10'd7) bad = 1;
    end
    chk("pause_hold", bad, 0);
    pause_a = 0;

    // Mode change lands in a tick cycle: the step is dropped, LEDs clear.
    wait_tick_a();
    mode_a = 2'b01;
    @(posedge clk); #1;
    chk("modechg_clear", runled_a, 0);
    step_a();
    chk("bounce_a_first", runled_a, 10'h001);

    mode_a = 2'b11; pattern_a = 10'h2A5;
    @(posedge clk); #1;
    chk("static_clear", runled_a, 0);
    @(posedge clk); #1;
    chk("static_first", runled_a, 10'h2A5);
    prev = 10'h2A5;
    for (int i = 0; i < 6; i++) begin
      pattern_a = tbl[i].pattern;
      pause_a   = tbl[i].pause;
      #1;
      chk("static_latency", runled_a, prev);
      @(posedge clk); #1;
      chk("static_vec", runled_a, tbl[i].exp);
      prev = tbl[i].exp;
    end
    pause_a = 0;

    mode_a = 2'b00;
    @(posedge clk); #1;
    chk("count_restart", runled_a, 0);
    repeat (1023) step_a();
    chk("count_3ff", runled_a, 10'h3FF);
    step_a();
    chk("count_wrap", runled_a, 0);

    mode_b = 2'b01;
    for (int i = 0; i < 8; i++) begin
      step_b();
      chk("bounce_seq", runled_b, btbl[i]);
    end
    step_b();
    chk("bounce_pre_rst", runled_b, 4'b0100);

    // Reset between edges must clear outputs immediately.
    #2 reset = 0;
    #1;
    chk("rst_async_b", runled_b, 0);
    chk("rst_async_a", runled_a, 0);
    repeat (2) @(negedge clk);
    reset = 1;
    step_b();
    chk("bounce_restart_0", runled_b, 4'b0001);
    step_b();
    chk("bounce_restart_1", runled_b, 4'b0010);

`ifdef LED_DRIVER_BREATHE_EN
    mode_b = 2'b10;
    repeat (5) step_b();
    pause_b = 1;
    measure_b(ones, mixed);
    chk("pwm_duty5", ones, 5);
    chk("pwm_uniform", mixed, 0);
    pause_b = 0;
    repeat (10) step_b();
    pause_b = 1;
    measure_b(ones, mixed);
    chk("pwm_duty15", ones, 15);
    pause_b = 0;
    step_b();
    pause_b = 1;
    measure_b(ones, mixed);
    chk("pwm_duty14", ones, 14);
    pause_b = 0;
`else
    mode_b = 2'b10;
    @(posedge clk); #1;
    bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (runled_b != 4'h0) bad = 1;
    end
    chk("breathe_off", bad, 0);
    chk("breathe_off_now", runled_b, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
